rr_scan_arbiter: RTL
====================

Name: rr_scan_arbiter

Overview:
- Round-robin arbiter for an 8-way shared serial channel: the 3-bit select / mux / one-hot decoder path that is today driven by a free-running counter.
- Replaces the free-running scan. Only requesters with a pending request get the channel, each for a bounded burst.
- Outputs a registered one-hot grant for the decoder side and a 3-bit index for the mux select.

Parameters:
MAX_HOLD, 4, maximum consecutive grant cycles per winner; legal range 1..15.

Ports:
CLK  input  1  clock, all state updates on posedge.
RST  input  1  synchronous active-high reset.
EN  input  1  arbitration enable; when low, no new grant is issued.
REQ_8  input  8  request lines; bit i = requester i.
GNT_8  output  8  registered one-hot grant; all zero when no grant.
IDX_3  output  3  index of the current or most recent winner; drives the mux select.
BUSY  output  1  high while in GRANT state (equals |GNT_8).

Behaviour:
- Reset (RST high at posedge, has priority over everything):
  - Outputs: GNT_8=0, IDX_3=0, BUSY=0.
  - Internal state: state=IDLE, LAST=7, HOLD_CNT=0.
  - LAST=7 gives requester 0 first priority after reset.
  - Reset mid-grant drops GNT_8 at that edge. No completion is owed.
- FSM states: IDLE, GRANT.
- IDLE, at each posedge:
  - If EN=1 and REQ_8!=0: winner W is the first set bit scanning LAST+1, LAST+2, ... modulo 8, with wrap 7->0.
  - On a win: GNT_8<=1<<W, IDX_3<=W, LAST<=W, HOLD_CNT<=1, state<=GRANT.
  - Otherwise: stay in IDLE; GNT_8 stays 0; IDX_3 and LAST hold.
- GRANT, at each posedge:
  - Release if REQ_8[IDX_3]==0 or HOLD_CNT==MAX_HOLD. Release sets GNT_8<=0, state<=IDLE.
  - Otherwise HOLD_CNT<=HOLD_CNT+1 and the grant holds.
  - Requests from other requesters are ignored while in GRANT (no preemption).
  - EN is ignored in GRANT; an active burst always completes.
- Latency:
  - Request sampled at edge k in IDLE appears on GNT_8 after edge k, i.e. one cycle.
  - Grant duration is min(MAX_HOLD, cycles the request stays high after grant), with a minimum of 1 cycle.
  - Between consecutive grants there is exactly one cycle with GNT_8=0 (the IDLE cycle). Back-to-back grants without a gap are never produced.
- Fairness: the requester just served has lowest priority at the next arbitration. With all 8 requesting continuously, grants rotate 0,1,...,7,0.
- A single requester holding REQ continuously is re-granted after each one-cycle gap, as the only candidate.
- Width rules:
  - HOLD_CNT is 4 bits and never exceeds MAX_HOLD.
  - LAST/IDX_3 wrap arithmetic is modulo 8.
- Invariants:
  - GNT_8 is always zero or one-hot.
  - When GNT_8!=0, GNT_8==1<<IDX_3.
  - BUSY==(state==GRANT).

Test Plan:
- Reset then RST=0, EN=1, REQ_8=8'b0000_0101 held (MAX_HOLD=4) -> GNT_8=0000_0001 for 4 cycles, 0 for 1 cycle, 0000_0100 for 4 cycles, 0 for 1 cycle, then 0000_0001 again; IDX_3 follows 0,2,0.
- REQ_8=8'hFF held -> grant index sequence 0,1,2,3,4,5,6,7,0. Each grant lasts 4 cycles, separated by 1 zero cycle.
- Wrap: after requester 6 is served, REQ_8=8'b1000_0001 -> next grant IDX_3=7, then IDX_3=0.
- Early release: REQ_8=8'b0000_1000; drop REQ_8[3] one cycle after the grant appears -> GNT_8=0000_1000 for exactly 1 cycle, then 0, BUSY=0.
- EN=0 with REQ_8=8'h10 -> GNT_8 stays 0. EN=1 -> GNT_8=0001_0000 one cycle later. EN=0 mid-grant -> burst still runs 4 cycles.
- RST=1 on the 2nd cycle of a grant to IDX_3=5 -> next cycle GNT_8=0, IDX_3=0, BUSY=0. With REQ_8=8'h21 afterwards, the first grant goes to IDX_3=0.

Source files
------------

// File: rtl/rr_scan_arbiter.sv
// rtl/rr_scan_arbiter.sv - 8-way round-robin arbiter with bounded burst hold for the shared serial channel mux
module rr_scan_arbiter #(
    parameter int MAX_HOLD = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       EN,
    input  logic [7:0] REQ_8,
    output logic [7:0] GNT_8,
    output logic [2:0] IDX_3,
    output logic       BUSY
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t     state, state_n;
    logic [7:0] gnt, gnt_n;
    logic [2:0] idx, idx_n;
    logic [2:0] last, last_n;
    logic [3:0] hold_cnt, hold_n;

    logic       found;
    logic [2:0] win;
    logic [2:0] cand;

    // Scan starts just past the last winner, so it ends up with lowest priority.
    always_comb begin
        found = 1'b0;
        win   = last;
        cand  = '0;
        for (int i = 1; i <= 8; i++) begin
            cand = last + 3'(i);
            if (!found && REQ_8[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    always_comb begin
        state_n = state;
        gnt_n   = gnt;
        idx_n   = idx;
        last_n  = last;
        hold_n  = hold_cnt;
        case (state)
            IDLE: begin
                gnt_n = '0;
                if (EN && found) begin
                    gnt_n   = 8'b1 << win;
                    idx_n   = win;
                    last_n  = win;
                    hold_n  = 4'd1;
                    state_n = GRANT;
                end
            end
            GRANT: begin
                // EN and other requesters are ignored here; a burst always completes.
                if (!REQ_8[idx] || hold_cnt == 4'(MAX_HOLD)) begin
                    gnt_n   = '0;
                    state_n = IDLE;
                end else begin
                    hold_n = hold_cnt + 4'd1;
                end
            end
            default: begin
                gnt_n   = '0;
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            gnt      <= '0;
            idx      <= '0;
            last     <= 3'd7;
            hold_cnt <= '0;
        end else begin
            state    <= state_n;
            gnt      <= gnt_n;
            idx      <= idx_n;
            last     <= last_n;
            hold_cnt <= hold_n;
        end
    end

    assign GNT_8 = gnt;
    assign IDX_3 = idx;
    assign BUSY  = (state == GRANT);

endmodule
